// File: rtl/map_controller.sv
// Tile map RAM owner: after reset or a clear command it writes the default level
// frame, then round-robin arbitrates one tile access per cycle and feeds a render
// read port every cycle.
// Latency: a grant, its rdata and its wr_reject are registered one edge after req
// is sampled. vid_tile is registered one edge after vid_x/vid_y.
// Backpressure: requesters hold req until gnt. No grants are issued while busy (init).
//
// Ports:
//   Clk, Reset_n           clock, synchronous active-low reset
//   clear_req              re-run the init sequence (ignored while busy)
//   req/req_we/req_x/req_y/req_wdata   packed per-requester access requests
//   gnt, rdata, wr_reject  one-hot grant pulse, read data, dropped-write flag
//   busy                   high while the init sequence runs
//   vid_x, vid_y, vid_tile render read port
//
// Build option: define MAP_CTRL_BORDER_PROTECT_EN to make border tiles read-only
// to requesters. Writes to border tiles are then dropped with wr_reject.
module map_controller #(
    parameter int MAP_W   = 20,
    parameter int MAP_H   = 15,
    parameter int TILE_W  = 3,
    parameter int NUM_REQ = 4,
    localparam int XW     = $clog2(MAP_W),
    localparam int YW     = $clog2(MAP_H)
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      clear_req,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*XW-1:0]     req_x,
    input  logic [NUM_REQ*YW-1:0]     req_y,
    input  logic [NUM_REQ*TILE_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [TILE_W-1:0]         rdata,
    output logic                      wr_reject,
    output logic                      busy,
    input  logic [XW-1:0]             vid_x,
    input  logic [YW-1:0]             vid_y,
    output logic [TILE_W-1:0]         vid_tile
);

    localparam int NT = MAP_W * MAP_H;
    localparam int AW = $clog2(NT);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TILE_W-1:0] WALL = TILE_W'(1);

`ifdef MAP_CTRL_BORDER_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    typedef enum logic {INIT, SERVE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx;
    logic [XW-1:0]     ix;          // x/y of idx, tracked alongside to avoid a divider
    logic [YW-1:0]     iy;
    logic [PW-1:0]     rr_ptr;
    logic [TILE_W-1:0] mem [NT];

    function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(y) * AW'(MAP_W) + AW'(x);
    endfunction

    function automatic logic is_oor(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (int'(x) >= MAP_W) || (int'(y) >= MAP_H);
    endfunction

    function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x == '0) || (int'(x) == MAP_W - 1) || (y == '0) || (int'(y) == MAP_H - 1);
    endfunction

    // Round-robin winner search. A requester granted last edge still has gnt high
    // this cycle and is masked so its held req is not granted twice.
    logic [NUM_REQ-1:0] elig;
    logic               win_vld;
    logic [PW-1:0]      win;

    always_comb begin
        elig    = req & ~gnt;
        win_vld = 1'b0;
        win     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && elig[(int'(rr_ptr) + i) % NUM_REQ]) begin
                win_vld = 1'b1;
                win     = PW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    logic              sel_we;
    logic [XW-1:0]     sel_x;
    logic [YW-1:0]     sel_y;
    logic [TILE_W-1:0] sel_wdata;
    logic [AW-1:0]     sel_addr;
    logic              sel_oor;
    logic              sel_rej;

    assign sel_we    = req_we[win];
    assign sel_x     = req_x[int'(win)*XW +: XW];
    assign sel_y     = req_y[int'(win)*YW +: YW];
    assign sel_wdata = req_wdata[int'(win)*TILE_W +: TILE_W];
    assign sel_addr  = addr_of(sel_x, sel_y);
    assign sel_oor   = is_oor(sel_x, sel_y);
    assign sel_rej   = sel_oor || (PROTECT && is_border(sel_x, sel_y));

    logic [AW-1:0] vid_addr;
    logic          vid_oor;

    assign vid_addr = addr_of(vid_x, vid_y);
    assign vid_oor  = is_oor(vid_x, vid_y);

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (int'(idx) == NT - 1) state_nxt = SERVE;
            SERVE:   if (clear_req)           state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    // Single RAM write port shared by the init sequencer and granted writes.
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [TILE_W-1:0] mem_wd;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (state == INIT) begin
            mem_we = 1'b1;
            mem_wa = idx;
            mem_wd = is_border(ix, iy) ? WALL : '0;
        end else if (!clear_req && win_vld && sel_we && !sel_rej) begin
            mem_we = 1'b1;
            mem_wa = sel_addr;
            mem_wd = sel_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset_n && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= INIT;
            idx       <= '0;
            ix        <= '0;
            iy        <= '0;
            rr_ptr    <= '0;
            gnt       <= '0;
            rdata     <= '0;
            wr_reject <= 1'b0;
            vid_tile  <= '0;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            gnt       <= '0;
            wr_reject <= 1'b0;
            // Reads the pre-write RAM contents, so a same-cycle write is not visible.
            vid_tile  <= (state == INIT) ? '0 : (vid_oor ? WALL : mem[vid_addr]);
            case (state)
                INIT: begin
                    if (state_nxt == SERVE) begin
                        busy <= 1'b0;
                        idx  <= '0;
                        ix   <= '0;
                        iy   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                        if (int'(ix) == MAP_W - 1) begin
                            ix <= '0;
                            iy <= iy + 1'b1;
                        end else begin
                            ix <= ix + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (clear_req) begin
                        busy <= 1'b1;
                        idx  <= '0;
                        ix   <= '0;
                        iy   <= '0;
                    end else if (win_vld) begin
                        gnt    <= NUM_REQ'(1) << win;
                        rr_ptr <= PW'((int'(win) + 1) % NUM_REQ);
                        if (sel_we) begin
                            wr_reject <= sel_rej;
                        end else begin
                            rdata <= sel_oor ? WALL : mem[sel_addr];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_map_controller.sv
module tb_map_controller;

    localparam int MAP_W   = 20;
    localparam int MAP_H   = 15;
    localparam int TILE_W  = 3;
    localparam int NUM_REQ = 4;
    localparam int XW      = 5;
    localparam int YW      = 4;
    localparam int NT      = MAP_W * MAP_H;

`ifdef MAP_CTRL_BORDER_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic                      Clk = 1'b0;
    logic                      Reset_n;
    logic                      clear_req;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*XW-1:0]     req_x;
    logic [NUM_REQ*YW-1:0]     req_y;
    logic [NUM_REQ*TILE_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [TILE_W-1:0]         rdata;
    logic                      wr_reject;
    logic                      busy;
    logic [XW-1:0]             vid_x;
    logic [YW-1:0]             vid_y;
    logic [TILE_W-1:0]         vid_tile;

    map_controller #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .TILE_W(TILE_W), .NUM_REQ(NUM_REQ)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .clear_req(clear_req),
        .req(req), .req_we(req_we), .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata),
        .gnt(gnt), .rdata(rdata), .wr_reject(wr_reject), .busy(busy),
        .vid_x(vid_x), .vid_y(vid_y), .vid_tile(vid_tile)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic       is_rd;
        logic [2:0] rdata;
        logic       rej;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic [TILE_W-1:0] mm [NT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_oor(input int x, input int y);
        return (x >= MAP_W) || (y >= MAP_H);
    endfunction

    function automatic bit m_border(input int x, input int y);
        return (x == 0) || (x == MAP_W - 1) || (y == 0) || (y == MAP_H - 1);
    endfunction

    task automatic model_init();
        for (int i = 0; i < NT; i++) mm[i] = m_border(i % MAP_W, i / MAP_W) ? 3'd1 : 3'd0;
    endtask

    function automatic logic [2:0] model_rd(input int x, input int y);
        return m_oor(x, y) ? 3'd1 : mm[y*MAP_W + x];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input string tag, input int i, input bit is_rd, input logic [2:0] rd, input bit rej);
        exp_t e;
        e.gnt = '0;
        e.gnt[i] = 1'b1;
        e.is_rd = is_rd;
        e.rdata = rd;
        e.rej   = rej;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    // Drive a request and push the model's expected response.
    task automatic set_req(input string tag, input int i, input bit we, input int x, input int y, input int wd);
        bit rej;
        req[i]    = 1'b1;
        req_we[i] = we;
        req_x[i*XW +: XW] = XW'(x);
        req_y[i*YW +: YW] = YW'(y);
        req_wdata[i*TILE_W +: TILE_W] = TILE_W'(wd);
        if (we) begin
            rej = m_oor(x, y) || (PROTECT && m_border(x, y));
            if (!rej) mm[y*MAP_W + x] = TILE_W'(wd);
            push(tag, i, 1'b0, 3'd0, rej);
        end else begin
            push(tag, i, 1'b1, model_rd(x, y), 1'b0);
        end
    endtask

    task automatic clr_req(input int i);
        req[i] = 1'b0;
    endtask

    // One edge on which the next scoreboard entry must be granted.
    task automatic step_grant();
        exp_t  e;
        string t;
        tick();
        if (sb.size() == 0) begin
            chk("unexpected_grant", 32'(gnt), 32'(0));
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            chk({t, "_gnt"}, 32'(gnt), 32'(e.gnt));
            if (e.is_rd) chk({t, "_rdata"}, 32'(rdata), 32'(e.rdata));
            chk({t, "_rej"}, 32'(wr_reject), 32'(e.rej));
        end
    endtask

    // Counts edges until busy falls, bounded; flags any grant seen meanwhile.
    task automatic wait_busy_low(output int n, output bit any_gnt);
        n = 0;
        any_gnt = 1'b0;
        do begin
            tick();
            n++;
            if (gnt != '0) any_gnt = 1'b1;
        end while (busy && n < 1000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0;
        bit ag;

        Reset_n = 1'b0; clear_req = 1'b0;
        req = '0; req_we = '0; req_x = '0; req_y = '0; req_wdata = '0;
        vid_x = '0; vid_y = '0;
        tick(); tick();
        chk("rst_gnt",      32'(gnt),       32'(0));
        chk("rst_rdata",    32'(rdata),     32'(0));
        chk("rst_wr_reject",32'(wr_reject), 32'(0));
        chk("rst_busy",     32'(busy),      32'(1));
        chk("rst_vid_tile", 32'(vid_tile),  32'(0));

        Reset_n = 1'b1;
        model_init();
        wait_busy_low(n, ag);
        chk("init_len", 32'(n), 32'(300));
        chk("init_no_gnt", 32'(ag), 32'(0));

        // All four requesters reading continuously from rr_ptr = 0.
        set_req("rr0", 0, 1'b0, 0, 0, 0);
        set_req("rr1", 1, 1'b0, 5, 5, 0);
        set_req("rr2", 2, 1'b0, 19, 14, 0);
        set_req("rr3", 3, 1'b0, 19, 5, 0);
        sb.delete(); sb_tag.delete();
        push("rr_a", 0, 1'b1, 3'd1, 1'b0);
        push("rr_b", 1, 1'b1, 3'd0, 1'b0);
        push("rr_c", 2, 1'b1, 3'd1, 1'b0);
        push("rr_d", 3, 1'b1, 3'd1, 1'b0);
        push("rr_e", 0, 1'b1, 3'd1, 1'b0);
        for (int k = 0; k < 5; k++) step_grant();
        req = '0;
        tick();
        chk("idle_gnt", 32'(gnt), 32'(0));

        // Write then read-after-write on the same tile, render sees old then new.
        vid_x = 5'd3; vid_y = 4'd2;
        set_req("wr_3_2", 1, 1'b1, 3, 2, 2);
        step_grant();
        chk("vid_old", 32'(vid_tile), 32'(0));
        clr_req(1);
        set_req("rd_3_2", 0, 1'b0, 3, 2, 0);
        step_grant();
        chk("vid_new", 32'(vid_tile), 32'(2));
        clr_req(0);

        // Border write and read-back.
        set_req("wr_0_5", 2, 1'b1, 0, 5, 0);
        step_grant();
        clr_req(2);
        set_req("rd_0_5", 3, 1'b0, 0, 5, 0);
        step_grant();
        clr_req(3);

        // Out-of-range accesses.
        set_req("rd_25_3", 0, 1'b0, 25, 3, 0);
        step_grant();
        clr_req(0);
        set_req("wr_5_15", 1, 1'b1, 5, 15, 2);
        step_grant();
        clr_req(1);
        set_req("wr_25_3", 2, 1'b1, 25, 3, 2);
        step_grant();
        clr_req(2);
        set_req("rd_5_4", 3, 1'b0, 5, 4, 0);
        step_grant();
        clr_req(3);
        set_req("rd_5_14", 0, 1'b0, 5, 14, 0);
        step_grant();
        clr_req(0);
        vid_x = 5'd20; vid_y = 4'd0;
        tick();
        chk("vid_oor_20_0", 32'(vid_tile), 32'(1));
        vid_x = 5'd25; vid_y = 4'd3;
        tick();
        chk("vid_oor_25_3", 32'(vid_tile), 32'(1));

        // Clear in SERVE with a read held through the whole init.
        set_req("wr_4_4", 1, 1'b1, 4, 4, 2);
        step_grant();
        clr_req(1);
        set_req("rd_4_4_pre", 0, 1'b0, 4, 4, 0);
        step_grant();
        clr_req(0);
        tick();
        vid_x = 5'd0; vid_y = 4'd0;
        model_init();
        set_req("rd_4_4_post_clear", 0, 1'b0, 4, 4, 0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clear_no_gnt", 32'(gnt), 32'(0));
        chk("clear_busy", 32'(busy), 32'(1));
        tick(); tick(); tick();
        chk("vid_init_zero", 32'(vid_tile), 32'(0));
        wait_busy_low(n0, ag);
        chk("clear_init_len", 32'(n0 + 3), 32'(300));
        chk("clear_init_no_gnt", 32'(ag), 32'(0));
        step_grant();
        clr_req(0);

        // Reset in the middle of init restarts the full sequence.
        set_req("wr_4_4_b", 1, 1'b1, 4, 4, 2);
        step_grant();
        clr_req(1);
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 150; k++) tick();
        Reset_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 32'(1));
        chk("midrst_gnt", 32'(gnt), 32'(0));
        chk("midrst_rdata", 32'(rdata), 32'(0));
        Reset_n = 1'b1;
        model_init();
        wait_busy_low(n, ag);
        chk("midrst_init_len", 32'(n), 32'(300));
        set_req("rd_4_4_after_rst", 2, 1'b0, 4, 4, 0);
        step_grant();
        clr_req(2);
        set_req("rd_19_0_after_rst", 3, 1'b0, 19, 0, 0);
        step_grant();
        clr_req(3);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/map_controller.md
# map_controller

Owns the playfield tile map RAM (MAP_W×MAP_H tiles) and time-shares it between game-logic requesters and the video renderer. After reset or a clear command it runs an init sequence that writes the default level frame: border walls = 1, interior = 0. It then round-robin arbitrates single-tile read/write requests, one per cycle. A dedicated render read port is serviced every cycle, independent of arbitration.

## Interface

Parameters:
- MAP_W, 20, map width in tiles
- MAP_H, 15, map height in tiles
- TILE_W, 3, tile code width
- NUM_REQ, 4, number of arbitrated requesters
- Derived widths: XW = $clog2(MAP_W) (5), YW = $clog2(MAP_H) (4)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- clear_req  in  1  pulse; re-run the init sequence
- req  in  NUM_REQ  per-requester request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_x  in  NUM_REQ*XW  tile x, packed with requester i at [i*XW +: XW]
- req_y  in  NUM_REQ*YW  tile y, packed likewise
- req_wdata  in  NUM_REQ*TILE_W  write tile code, packed likewise
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- rdata  out  TILE_W  read data, valid while gnt is high for a read
- wr_reject  out  1  pulse with gnt; the write was dropped
- busy  out  1  high during init
- vid_x  in  XW  render tile x
- vid_y  in  YW  render tile y
- vid_tile  out  TILE_W  render tile code, 1-cycle latency

## Operation

- States: INIT, SERVE.
- Linear address = y*MAP_W + x.
- A coordinate is out-of-range (OOR) when x ≥ MAP_W or y ≥ MAP_H.
- A tile is a border tile when x = 0, x = MAP_W−1, y = 0 or y = MAP_H−1.

INIT:
- Counter idx runs 0…MAP_W*MAP_H−1 and writes one tile per cycle: 1 if border, else 0.
- After the write of the last idx: go to SERVE and deassert busy.
- No grants are issued; requesters keep req held.
- clear_req is ignored.

SERVE arbitration:
- Eligible = req & ~gnt. A requester granted this cycle is masked for this cycle.
- The winner is the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
- On the clock edge:
  - gnt ← onehot(winner)
  - the access is performed
  - rr_ptr ← (winner+1) mod NUM_REQ
- With no eligible requester: gnt ← 0 and rr_ptr holds.

Access rules:
- Read: rdata ← mem[addr]; an OOR address returns 1 (wall).
- Write to an OOR address: dropped, wr_reject = 1.
- Write with border protection active (see Configuration): dropped, wr_reject = 1.
- Otherwise: mem[addr] ← wdata.
- wr_reject is 0 for reads.

Render port:
- Each cycle: vid_tile ← mem[vid addr], or 1 if the render address is OOR.
- Forced to 0 while in INIT.

Other events:
- clear_req in SERVE: next state INIT, idx ← 0, busy ← 1, gnt ← 0. Any request present that cycle is not granted.
- Reset_n low at any edge, in any state, mid-init or mid-access:
  - state ← INIT, idx ← 0, rr_ptr ← 0
  - gnt ← 0, rdata ← 0, wr_reject ← 0, vid_tile ← 0, busy ← 1

## Timing

- Reset values: gnt 0, rdata 0, wr_reject 0, busy 1, vid_tile 0.
- Init length: MAP_W*MAP_H cycles (300 at defaults). busy falls on the 300th rising edge with Reset_n high.
- Request latency: req sampled high at edge N produces gnt/rdata/wr_reject valid during cycle N→N+1.
- Requester handshake: deassert req, or present the next request, in the cycle gnt is high. A single requester can therefore be granted at most every other cycle.
- Throughput: up to one access per cycle across requesters.
- Same-tile conflicts:
  - Render read and granted write in the same cycle: the render sees the old value.
  - A read granted the cycle after a write to the same tile sees the new value.

## Configuration

- MAP_CTRL_BORDER_PROTECT_EN defined:
  - writes to border tiles are dropped with wr_reject = 1
  - walls are immutable to game logic
- Not defined:
  - border writes succeed like interior writes
  - only OOR writes are rejected

## Test plan

- Reset_n low 2 cycles then high: busy falls after exactly 300 edges. Reads then return (0,0) → 1, (5,5) → 0, (19,14) → 1, (19,5) → 1.
- Requester 1 writes (3,2) = 2; the next cycle requester 0 reads (3,2): gnt = 0001, rdata = 2. vid_x/vid_y = (3,2) gives vid_tile = 2 one cycle later.
- All four requesters reading held continuously from rr_ptr = 0: gnt sequence 0001, 0010, 0100, 1000, 0001, with the masked requester skipped each cycle.
- Write (0,5) = 0:
  - with MAP_CTRL_BORDER_PROTECT_EN: wr_reject = 1 and a later read of (0,5) returns 1
  - without it: wr_reject = 0 and the read returns 0
- Read (25,3) returns rdata = 1. Write (5,15) = 2 gives wr_reject = 1 with memory unchanged. Render (20,0) gives vid_tile = 1.
- Write (4,4) = 2, then pulse clear_req in SERVE: busy high for 300 cycles, no grants while req is held, and afterwards (4,4) reads 0. Repeat with Reset_n low mid-init at idx 150: init restarts from idx 0.
